// File: rtl/latch_ff_checker_pkg.sv
// latch_ff_checker_pkg: shared types and constants for the latch/FF self-check stage.
// Provides lfc_state_t, default WIN_W/CNT_W and the upstream data width LF_DW.
package latch_ff_checker_pkg;

    localparam int LF_DW      = 4;
    localparam int WIN_W_DFLT = 8;
    localparam int CNT_W_DFLT = 8;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        CHECK,
        REPORT
    } lfc_state_t;

endpackage

// File: rtl/latch_ff_checker_sat_cnt.sv
// sat_cnt: clearable up-counter that sticks at all-ones instead of wrapping.
// Ports: clk, rst (async active-low), clr, inc, cnt[W-1:0].
module sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/latch_ff_checker.sv
// latch_ff_checker: windowed self-check of latch_ff outputs; d_r_out must equal
// the latch output of the previous cycle while en was high; counts mismatches and
// d_f_out toggles, then reports over res_valid/res_ready.
// Ports: clk, rst (async active-low), en, l_out, d_r_out, d_f_out, start, win_len,
// busy, res_valid, res_ready, err_cnt, tog_cnt.
// Optional LATCH_FF_CHK_FIRST_ERR_EN: adds first_err_vld/idx/exp/got capture of
// the first mismatch in a window.
module latch_ff_checker
    import latch_ff_checker_pkg::*;
#(
    parameter int WIN_W = WIN_W_DFLT,
    parameter int CNT_W = CNT_W_DFLT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [LF_DW-1:0] l_out,
    input  logic [LF_DW-1:0] d_r_out,
    input  logic [LF_DW-1:0] d_f_out,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] err_cnt,
`ifdef LATCH_FF_CHK_FIRST_ERR_EN
    output logic [CNT_W-1:0] tog_cnt,
    output logic             first_err_vld,
    output logic [WIN_W-1:0] first_err_idx,
    output logic [LF_DW-1:0] first_err_exp,
    output logic [LF_DW-1:0] first_err_got
`else
    output logic [CNT_W-1:0] tog_cnt
`endif
);

    lfc_state_t       state_q;
    lfc_state_t       state_d;
    logic [WIN_W-1:0] win_cnt_q;
    logic [LF_DW-1:0] l_q;
    logic [LF_DW-1:0] df_q;
    logic             en_q;
    logic             accept;
    logic             in_check;
    logic             mismatch;
    logic             toggle;

    assign accept   = (state_q == IDLE) && start && (win_len != '0);
    assign in_check = (state_q == CHECK);
    // en_q low means the upstream FF was holding: never a mismatch.
    assign mismatch = in_check && en_q && (d_r_out != l_q);
    assign toggle   = in_check && (d_f_out != df_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (accept) state_d = ARM;
            ARM:    state_d = CHECK;
            CHECK:  if (win_cnt_q == WIN_W'(1)) state_d = REPORT;
            REPORT: if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        res_valid = (state_q == REPORT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_cnt_q <= '0;
        end else if (accept) begin
            win_cnt_q <= win_len;
        end else if (in_check) begin
            win_cnt_q <= win_cnt_q - WIN_W'(1);
        end
    end

    // History: primed in ARM so the first CHECK cycle has a reference.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            l_q  <= '0;
            df_q <= '0;
            en_q <= 1'b0;
        end else if ((state_q == ARM) || in_check) begin
            l_q  <= l_out;
            df_q <= d_f_out;
            en_q <= en;
        end
    end

    sat_cnt #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .inc (mismatch),
        .cnt (err_cnt)
    );

    sat_cnt #(.W(CNT_W)) u_tog_cnt (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .inc (toggle),
        .cnt (tog_cnt)
    );

`ifdef LATCH_FF_CHK_FIRST_ERR_EN
    logic [WIN_W-1:0] win_len_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_len_q     <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else if (accept) begin
            win_len_q     <= win_len;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else if (mismatch && !first_err_vld) begin
            first_err_vld <= 1'b1;
            // win_cnt_q counts down from win_len, so this is the 0-based index.
            first_err_idx <= win_len_q - win_cnt_q;
            first_err_exp <= l_q;
            first_err_got <= d_r_out;
        end
    end
`endif

endmodule

// File: tb/tb_latch_ff_checker.sv
// tb_latch_ff_checker: directed table-driven bench for latch_ff_checker,
// with a second CNT_W=2 instance for saturation.
module tb_latch_ff_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] l_out;
    logic [3:0] d_r_out;
    logic [3:0] d_f_out;
    logic       start;
    logic [7:0] win_len;
    logic       res_ready;
    logic       busy;
    logic       res_valid;
    logic [7:0] err_cnt;
    logic [7:0] tog_cnt;
    logic       busy2;
    logic       res_valid2;
    logic [1:0] err_cnt2;
    logic [1:0] tog_cnt2;
`ifdef LATCH_FF_CHK_FIRST_ERR_EN
    logic       fe_vld;
    logic [7:0] fe_idx;
    logic [3:0] fe_exp;
    logic [3:0] fe_got;
    logic       fe_vld2;
    logic [7:0] fe_idx2;
    logic [3:0] fe_exp2;
    logic [3:0] fe_got2;
`endif

    int pass_cnt = 0;
    int total    = 0;
    int mode     = 0;

    always #5 clk = ~clk;

    latch_ff_checker dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .l_out     (l_out),
        .d_r_out   (d_r_out),
        .d_f_out   (d_f_out),
        .start     (start),
        .win_len   (win_len),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .err_cnt   (err_cnt),
`ifdef LATCH_FF_CHK_FIRST_ERR_EN
        .tog_cnt       (tog_cnt),
        .first_err_vld (fe_vld),
        .first_err_idx (fe_idx),
        .first_err_exp (fe_exp),
        .first_err_got (fe_got)
`else
        .tog_cnt   (tog_cnt)
`endif
    );

    latch_ff_checker #(.WIN_W(8), .CNT_W(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .l_out     (l_out),
        .d_r_out   (d_r_out),
        .d_f_out   (d_f_out),
        .start     (start),
        .win_len   (win_len),
        .busy      (busy2),
        .res_valid (res_valid2),
        .res_ready (res_ready),
        .err_cnt   (err_cnt2),
`ifdef LATCH_FF_CHK_FIRST_ERR_EN
        .tog_cnt       (tog_cnt2),
        .first_err_vld (fe_vld2),
        .first_err_idx (fe_idx2),
        .first_err_exp (fe_exp2),
        .first_err_got (fe_got2)
`else
        .tog_cnt   (tog_cnt2)
`endif
    );

    typedef struct {
        int win;
        int mode;
        int exp_err;
        int exp_tog;
        int exp_err2;
        int exp_tog2;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    endtask

    // Data patterns applied on every negedge:
    // 0: en=1, d_r_out tracks l_out one cycle late, d_f_out steady
    // 1: en=1, l_out=5, d_r_out=A, d_f_out steady
    // 2: en=0, mismatching data, d_f_out alternates 0/F
    // 3: en=1, l_out=5, d_r_out=A, d_f_out alternates 0/F
    task automatic drive();
        logic [3:0] prev;
        prev = l_out;
        unique case (mode)
            0: begin
                en = 1'b1; l_out = l_out + 4'd3; d_r_out = prev;
            end
            1: begin
                en = 1'b1; l_out = 4'h5; d_r_out = 4'hA;
            end
            2: begin
                en = 1'b0; l_out = 4'($urandom); d_r_out = ~l_out;
                d_f_out = d_f_out ^ 4'hF;
            end
            default: begin
                en = 1'b1; l_out = 4'h5; d_r_out = 4'hA;
                d_f_out = d_f_out ^ 4'hF;
            end
        endcase
    endtask

    // Issues start, returns k = posedges from the start edge to the first
    // edge that samples res_valid high (0 if it never came).
    task automatic launch(input int win, input int md, output int k);
        bit seen;
        @(negedge clk);
        mode = md; drive();
        win_len = 8'(win); start = 1'b1;
        @(negedge clk);
        start = 1'b0; drive();
        chk("busy_rise", busy, 1);
        k = 1; seen = 0;
        while (!seen && k < 400) begin
            if (res_valid) seen = 1;
            else begin
                @(negedge clk); drive(); k++;
            end
        end
        if (!seen) begin
            chk("res_valid_timeout", 0, 1);
            k = 0;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int k;
        launch(v.win, v.mode, k);
        chk($sformatf("lat_w%0d", v.win), k, v.win + 2);
        chk($sformatf("err_w%0d_m%0d", v.win, v.mode), err_cnt, v.exp_err);
        chk($sformatf("tog_w%0d_m%0d", v.win, v.mode), tog_cnt, v.exp_tog);
        chk($sformatf("err2_w%0d", v.win), err_cnt2, v.exp_err2);
        chk($sformatf("tog2_w%0d", v.win), tog_cnt2, v.exp_tog2);
`ifdef LATCH_FF_CHK_FIRST_ERR_EN
        chk("fe_vld", fe_vld, (v.exp_err > 0) ? 1 : 0);
        if (v.exp_err > 0) begin
            chk("fe_idx", fe_idx, 0);
            chk("fe_exp", fe_exp, 4'h5);
            chk("fe_got", fe_got, 4'hA);
        end
`endif
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0; drive();
        chk("valid_drop", res_valid, 0);
        chk("idle_after_hs", busy, 0);
        chk("err_hold", err_cnt, v.exp_err);
    endtask

    vec_t vecs[7];

    initial begin
        int k;
        vecs[0] = '{4,   0, 0,   0, 0, 0};
        vecs[1] = '{5,   1, 5,   0, 3, 0};
        vecs[2] = '{8,   2, 0,   8, 0, 3};
        vecs[3] = '{6,   1, 6,   0, 3, 0};
        vecs[4] = '{1,   2, 0,   1, 0, 1};
        vecs[5] = '{7,   3, 7,   7, 3, 3};
        vecs[6] = '{255, 1, 255, 0, 3, 0};

        rst = 1'b0; en = 1'b0; l_out = '0; d_r_out = '0; d_f_out = '0;
        start = 1'b0; win_len = '0; res_ready = 1'b0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_tog", tog_cnt, 0);
        @(negedge clk);
        rst = 1'b1;

        // start with win_len=0 ignored; res_ready without res_valid harmless
        @(negedge clk);
        start = 1'b1; win_len = 8'd0; res_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; res_ready = 1'b0;
        chk("zero_win_ignored", busy, 0);
        chk("ready_no_valid", res_valid, 0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // reset in CHECK after 3 mismatches
        @(negedge clk);
        mode = 1; drive(); win_len = 8'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0; drive();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); drive();
        end
        chk("pre_rst_err", err_cnt, 3);
        #2 rst = 1'b0;
        #1;
        chk("midrst_err", err_cnt, 0);
        chk("midrst_tog", tog_cnt, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", res_valid, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); drive();
            if (i == 14) begin
                chk("postrst_valid", res_valid, 0);
                chk("postrst_busy", busy, 0);
            end
        end

        // REPORT stall with start pulse in between, then start during handshake
        launch(3, 1, k);
        chk("stall_lat", k, 5);
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            win_len = 8'd5;
            @(negedge clk); drive();
            chk($sformatf("stall_valid_%0d", i), res_valid, 1);
            chk($sformatf("stall_err_%0d", i), err_cnt, 3);
        end
        start = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; res_ready = 1'b0;
        chk("hs_start_ignored", busy, 0);
        chk("hs_valid_low", res_valid, 0);
        chk("hs_err_kept", err_cnt, 3);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
